piso_serializer: RTL and testbench

Parallel-in/serial-out stage that sits directly upstream of the 4-bit SIPO deserializer and drives its serial input. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock. A one-word holding buffer lets back-to-back words stream with no idle gap between frames. It also emits per-bit valid and frame-start markers for the downstream stage.

---
 rtl/piso_serializer_if.sv | 22 ++
 rtl/piso_serializer.sv | 90 +++++++++
 tb/tb_piso_serializer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// Word-in / bit-out bundle of the serializer: parallel handshake plus serial stream with markers.
interface piso_serializer_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] data_in;
   logic             data_valid;
   logic             data_ready;
   logic             serial_out;
   logic             serial_valid;
   logic             frame_start;
   logic             busy;

   modport master (
      output data_in, data_valid,
      input  data_ready, serial_out, serial_valid, frame_start, busy
   );

   modport slave (
      input  data_in, data_valid,
      output data_ready, serial_out, serial_valid, frame_start, busy
   );
endinterface

// File: rtl/piso_serializer.sv
// PISO serializer: first bit the cycle after accept, WIDTH cycles per word, no gap when streaming.
// Backpressure: data_ready = !hold_full; a one-word holding buffer covers the frame in flight.
module piso_serializer #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   piso_serializer_if.slave bus
);
   localparam int              CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [WIDTH-1:0] hold_data_q, hold_data_d;
   logic [WIDTH-1:0] sreg_shift;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             active_q, active_d;
   logic             hold_full_q, hold_full_d;
   logic             last;
   logic             accept;

   assign last   = active_q && (cnt_q == CNT_LAST);
   assign accept = bus.data_valid && !hold_full_q;

   generate
      if (MSB_FIRST) begin : g_msb
         assign sreg_shift = {sreg_q[WIDTH-2:0], 1'b0};
      end else begin : g_lsb
         assign sreg_shift = {1'b0, sreg_q[WIDTH-1:1]};
      end
   endgenerate

   always_comb begin
      sreg_d      = sreg_q;
      hold_data_d = hold_data_q;
      cnt_d       = cnt_q;
      active_d    = active_q;
      hold_full_d = hold_full_q;

      if (active_q && !last) begin
         cnt_d  = cnt_q + CNT_W'(1);
         sreg_d = sreg_shift;
      end

      // End of frame: chain the held word, otherwise go idle unless a fresh word lands now.
      if (last) begin
         if (hold_full_q) begin
            sreg_d      = hold_data_q;
            cnt_d       = '0;
            hold_full_d = 1'b0;
         end else if (!accept) begin
            active_d = 1'b0;
         end
      end

      if (accept) begin
         if (!active_q || last) begin
            sreg_d   = bus.data_in;
            active_d = 1'b1;
            cnt_d    = '0;
         end else begin
            hold_data_d = bus.data_in;
            hold_full_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sreg_q      <= '0;
         hold_data_q <= '0;
         cnt_q       <= '0;
         active_q    <= 1'b0;
         hold_full_q <= 1'b0;
      end else begin
         sreg_q      <= sreg_d;
         hold_data_q <= hold_data_d;
         cnt_q       <= cnt_d;
         active_q    <= active_d;
         hold_full_q <= hold_full_d;
      end
   end

   assign bus.data_ready   = !hold_full_q;
   assign bus.serial_out   = active_q & (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);
   assign bus.serial_valid = active_q;
   assign bus.frame_start  = active_q && (cnt_q == '0);
   assign bus.busy         = active_q | hold_full_q;
endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance, scoreboarded bit by bit,
// with a 4-bit SIPO model looped back on the MSB-first output.
module tb_piso_serializer;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   piso_serializer_if #(.WIDTH(4)) bus_m ();
   piso_serializer_if #(.WIDTH(4)) bus_l ();

   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .reset(reset), .bus(bus_m));
   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .reset(reset), .bus(bus_l));

   logic       vld [2];
   logic [3:0] din [2];
   logic [1:0] sv, so, fs, bsy, rdy;

   assign bus_m.data_valid = vld[0];
   assign bus_m.data_in    = din[0];
   assign bus_l.data_valid = vld[1];
   assign bus_l.data_in    = din[1];
   assign sv  = {bus_l.serial_valid, bus_m.serial_valid};
   assign so  = {bus_l.serial_out,   bus_m.serial_out};
   assign fs  = {bus_l.frame_start,  bus_m.frame_start};
   assign bsy = {bus_l.busy,         bus_m.busy};
   assign rdy = {bus_l.data_ready,   bus_m.data_ready};

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Scoreboard entries are {frame_start, bit}.
   logic [1:0] exp_q [2][$];
   logic [3:0] tx_q  [2][$];
   logic [3:0] lbw_q [$];

   int cyc = 0;
   int acc_cyc [2];
   int first_vld_cyc [2];
   int vrun [2];
   int irun [2];
   int last_run [2];
   int last_gap [2];
   int nbits [2];
   int nrdy_lo [2];
   int lb_cd = 0;
   int nlb = 0;
   logic [3:0] lb_word = '0;
   logic [3:0] sipo;

   always @(posedge clk) cyc++;

   always @(posedge clk or negedge reset) begin
      if (!reset) sipo <= '0;
      else if (sv[0]) sipo <= {sipo[2:0], so[0]};
   end

   // Driver: offers the head word when ready; while stalled, data_in carries junk that must be ignored.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!reset || tx_q[d].size() == 0) begin
            vld[d] = 1'b0;
            din[d] = '0;
         end else if (rdy[d]) begin
            vld[d]     = 1'b1;
            din[d]     = tx_q[d].pop_front();
            acc_cyc[d] = cyc;
            for (int i = 0; i < 4; i++)
               exp_q[d].push_back({(i == 0), (d == 0) ? din[d][3-i] : din[d][i]});
            if (d == 0) lbw_q.push_back(din[d]);
         end else begin
            vld[d] = 1'b1;
            din[d] = 4'($urandom);
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         for (int d = 0; d < 2; d++) begin
            exp_q[d].delete();
            vrun[d] = 0;
            irun[d] = 0;
         end
         lbw_q.delete();
         lb_cd = 0;
      end else begin
         if (lb_cd != 0) begin
            lb_cd--;
            if (lb_cd == 0) begin
               chk("loopback", 32'(sipo), 32'(lb_word));
               nlb++;
            end
         end
         if (sv[0] && fs[0] && lbw_q.size() > 0) begin
            lb_word = lbw_q.pop_front();
            lb_cd   = 4;
         end
         for (int d = 0; d < 2; d++) begin
            logic [1:0] e;
            if (!rdy[d]) nrdy_lo[d]++;
            if (sv[d]) begin
               if (vrun[d] == 0) begin
                  last_gap[d]      = irun[d];
                  first_vld_cyc[d] = cyc;
               end
               vrun[d]++;
               irun[d] = 0;
               nbits[d]++;
               if (exp_q[d].size() == 0) begin
                  chk("extra_bit", 32'(1), 32'(0));
               end else begin
                  e = exp_q[d].pop_front();
                  chk((d == 0) ? "bit_msb" : "bit_lsb", 32'(so[d]), 32'(e[0]));
                  chk((d == 0) ? "fs_msb" : "fs_lsb", 32'(fs[d]), 32'(e[1]));
               end
            end else begin
               if (vrun[d] > 0) last_run[d] = vrun[d];
               vrun[d] = 0;
               irun[d]++;
               chk("idle_so", 32'(so[d]), 32'(0));
               chk("idle_fs", 32'(fs[d]), 32'(0));
            end
         end
      end
   end

   task automatic wait_idle(input int d);
      int  k;
      bit  done;
      k    = 0;
      done = 1'b0;
      while (!done && k < 300) begin
         @(negedge clk);
         k++;
         done = (tx_q[d].size() == 0) && (exp_q[d].size() == 0) && !bsy[d];
      end
      if (!done) chk("idle_timeout", 32'(0), 32'(1));
   endtask

   initial begin
      int n0;
      int k;
      reset = 1'b0;
      for (int d = 0; d < 2; d++) begin
         vld[d] = 1'b0;
         din[d] = '0;
         nbits[d] = 0;
         nrdy_lo[d] = 0;
         last_run[d] = 0;
         last_gap[d] = 0;
         acc_cyc[d] = 0;
         first_vld_cyc[d] = 0;
      end
      #12;
      for (int d = 0; d < 2; d++) begin
         chk("rst_sv", 32'(sv[d]), 32'(0));
         chk("rst_so", 32'(so[d]), 32'(0));
         chk("rst_fs", 32'(fs[d]), 32'(0));
         chk("rst_busy", 32'(bsy[d]), 32'(0));
         chk("rst_rdy", 32'(rdy[d]), 32'(1));
      end
      @(posedge clk); #2 reset = 1'b1;

      // Single word on an idle block.
      @(posedge clk); #1 tx_q[0].push_back(4'b1011);
      wait_idle(0);
      @(posedge clk);
      chk("t1_latency", 32'(first_vld_cyc[0] - acc_cyc[0]), 32'(1));
      chk("t1_len", 32'(last_run[0]), 32'(4));
      chk("t1_busy", 32'(bsy[0]), 32'(0));

      // Streaming three words: continuous bits and two held-word stalls of three cycles each.
      n0 = nrdy_lo[0];
      #1;
      tx_q[0].push_back(4'hA);
      tx_q[0].push_back(4'h5);
      tx_q[0].push_back(4'hC);
      wait_idle(0);
      @(posedge clk);
      chk("t2_len", 32'(last_run[0]), 32'(12));
      chk("t2_rdy_low", 32'(nrdy_lo[0] - n0), 32'(6));

      // LSB-first with a three-cycle gap between words.
      #1 tx_q[1].push_back(4'b0001);
      wait_idle(1);
      @(posedge clk); #1;
      @(posedge clk); #1 tx_q[1].push_back(4'b1100);
      wait_idle(1);
      @(posedge clk);
      chk("t3_gap", 32'(last_gap[1]), 32'(3));
      chk("t3_len", 32'(last_run[1]), 32'(4));

      // Asynchronous reset mid-frame with a word held.
      n0 = nbits[0];
      #1;
      tx_q[0].push_back(4'hF);
      tx_q[0].push_back(4'h3);
      k = 0;
      while (nbits[0] < n0 + 2 && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (nbits[0] < n0 + 2) chk("t4_timeout", 32'(0), 32'(1));
      @(posedge clk); #1;
      chk("t4_rdy_held", 32'(rdy[0]), 32'(0));
      chk("t4_so_pre", 32'(so[0]), 32'(1));
      #1 reset = 1'b0;
      #1;
      chk("t4_sv_async", 32'(sv[0]), 32'(0));
      chk("t4_so_async", 32'(so[0]), 32'(0));
      chk("t4_fs_async", 32'(fs[0]), 32'(0));
      chk("t4_busy_async", 32'(bsy[0]), 32'(0));
      chk("t4_rdy_async", 32'(rdy[0]), 32'(1));
      @(negedge clk);
      @(negedge clk);
      @(posedge clk); #2 reset = 1'b1;
      #1;
      chk("t4_rdy_rel", 32'(rdy[0]), 32'(1));
      chk("t4_busy_rel", 32'(bsy[0]), 32'(0));
      tx_q[0].push_back(4'h6);
      wait_idle(0);
      @(posedge clk);
      chk("t4_len", 32'(last_run[0]), 32'(4));

      // Back-to-back pair through the loopback SIPO, junk on data_in while stalled.
      #1;
      tx_q[0].push_back(4'h9);
      tx_q[0].push_back(4'h6);
      wait_idle(0);
      @(posedge clk);
      chk("t6_len", 32'(last_run[0]), 32'(8));
      chk("loopback_count", 32'(nlb), 32'(7));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
